// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset main controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] PC_REG = 4'd15;

    // C and V are only meaningful for the arithmetic operations.
    function automatic logic cv_applies(input logic [1:0] alu_ctl);
        return (alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps Funct[4:1]/S to ALU operation, flag-write and CMP suppression.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       enable,
    input  logic [5:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);

    logic cmd_valid_s;

    // Decode the data-processing command; unknown commands act as a flag-less, write-suppressed ADD.
    always_comb begin
        ALUControl  = ALU_ADD;
        FlagW       = 2'b00;
        NoWrite     = 1'b0;
        cmd_valid_s = 1'b0;
        if (enable) begin
            cmd_valid_s = 1'b1;
            case (Funct[4:1])
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: begin
                    ALUControl = ALU_SUB;
                    NoWrite    = 1'b1;
                end
                default: begin
                    ALUControl  = ALU_ADD;
                    NoWrite     = 1'b1;
                    cmd_valid_s = 1'b0;
                end
            endcase
            if (cmd_valid_s) begin
                FlagW = {Funct[0], Funct[0] & cv_applies(ALUControl)};
            end else begin
                FlagW = 2'b00;
            end
        end else begin
            cmd_valid_s = 1'b0;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle main controller: Moore FSM over fetch/decode/execute/memory/writeback
// producing unconditional control requests and datapath selects.
module control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic       irwrite_s, nextpc_s, regw_s, memw_s, branch_s, alu_en_s;
    logic [1:0] dec_flagw_s;
    logic       dec_nowrite_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode; selects keep their FETCH values while in reset since state is FETCH.
    always_comb begin
        irwrite_s = 1'b0;
        nextpc_s  = 1'b0;
        regw_s    = 1'b0;
        memw_s    = 1'b0;
        branch_s  = 1'b0;
        alu_en_s  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                nextpc_s  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_EXTIMM;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                regw_s    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                memw_s = 1'b1;
            end
            S_EXECR:  alu_en_s = 1'b1;
            S_EXECI: begin
                ALUSrcB  = SRCB_EXTIMM;
                alu_en_s = 1'b1;
            end
            S_ALUWB: begin
                regw_s   = 1'b1;
                alu_en_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                branch_s  = 1'b1;
            end
            default: irwrite_s = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .enable     (alu_en_s),
        .Funct      (Funct),
        .ALUControl (ALUControl),
        .FlagW      (dec_flagw_s),
        .NoWrite    (dec_nowrite_s)
    );

    // Strobes are masked by reset so an abandoned instruction can emit nothing.
    assign IRWrite = irwrite_s & rst_n;
    assign NextPC  = nextpc_s & rst_n;
    assign RegW    = regw_s & rst_n;
    assign MemW    = memw_s & rst_n;
    assign NoWrite = dec_nowrite_s & rst_n;
    assign FlagW   = dec_flagw_s & {2{rst_n}};
    assign PCS     = (branch_s | (regw_s & (Rd == PC_REG))) & rst_n;
    assign ImmSrc  = Op;
    assign RegSrc  = {(Op == OP_MEM), (Op == OP_BR)};
    assign state   = state_q;

endmodule
